tree_fanin_collector: RTL and testbench
=======================================

TREE_FANIN_COLLECTOR -- requirements
Module: tree_fanin_collector

Interface
REQ-001 SHALL have parameter NUM_CHILD, default 5, meaning number of child sources merged (2..8).
REQ-002 SHALL have parameter DATA_W, default 8, meaning child payload width.
REQ-003 SHALL have parameter DEPTH, default 4, meaning output FIFO entries (power of two, >=2).
REQ-004 SHALL have port clk, input, 1, meaning the only clock; all state on rising edge.
REQ-005 SHALL have port rst_n, input, 1, meaning asynchronous active-low reset.
REQ-006 SHALL have port child_valid, input, NUM_CHILD, meaning per-child data valid.
REQ-007 SHALL have port child_data, input, NUM_CHILD*DATA_W, meaning child i payload in bits [i*DATA_W +: DATA_W].
REQ-008 SHALL have port child_ready, output, NUM_CHILD, meaning per-child accept; at most one bit high per cycle.
REQ-009 SHALL have port out_valid, output, 1, meaning FIFO head valid.
REQ-010 SHALL have port out_data, output, DATA_W, meaning FIFO head payload.
REQ-011 SHALL have port out_src, output, 3, meaning child index of FIFO head.
REQ-012 SHALL have port out_ready, input, 1, meaning downstream accept.
REQ-013 SHALL have port drop_cnt, output, 16, meaning saturating count of cycles with any child_valid while FIFO full.

Function
REQ-014 SHALL transfer on a child when child_valid[i] && child_ready[i], and on output when out_valid && out_ready.
REQ-015 SHALL assert child_ready only for the round-robin winner, and only when the FIFO is not full or a pop occurs in the same cycle.
REQ-016 SHALL select the winner as the first valid child at or after index (last_grant+1) mod NUM_CHILD; last_grant updates only on an accepted transfer.
REQ-017 SHALL drive child_ready combinationally from child_valid, last_grant, FIFO count and out_ready (no cycle latency on accept).
REQ-018 SHALL make accepted data visible on out_valid/out_data/out_src the cycle after acceptance (one-cycle latency, registered FIFO).
REQ-019 SHALL, on simultaneous push and pop, keep count unchanged, including when full (push permitted) and when count is 1.
REQ-020 SHALL NOT pop when empty; out_valid low when count is 0; out_data/out_src hold last values when empty.
REQ-021 SHALL wrap read/write pointers modulo DEPTH; count width clog2(DEPTH)+1.
REQ-022 SHALL preserve acceptance order at the output (FIFO order, no reordering).
REQ-023 SHALL increment drop_cnt by 1 per cycle where any child_valid is high and no child is accepted due to full FIFO; saturate at 16'hFFFF.

Reset
REQ-024 SHALL, on rst_n low, asynchronously clear pointers, count, drop_cnt to 0 and set last_grant to NUM_CHILD-1 (child 0 wins first).
REQ-025 SHALL hold out_valid=0, child_ready=0, out_data=0, out_src=0 during reset; in-flight FIFO contents are discarded.
REQ-026 SHALL deassert reset synchronously to clk externally; no internal synchronizer.

Structure
REQ-027 SHALL place SRC_W=3 and the max NUM_CHILD constant in shared package tree_pkg.
REQ-028 SHALL implement the arbiter as sub-module tree_rr_arbiter (request vector, last_grant in, one-hot grant out); FIFO inline.

Verification
REQ-029 SHALL cover: reset, all 5 children valid, out_ready=1 -> out_src sequence 0,1,2,3,4,0 on consecutive cycles, one cycle after first accept.
REQ-030 SHALL cover: only child 3 valid with data 8'hA5, out_ready=1 -> child_ready[3] every cycle, out_data=8'hA5, out_src=3.
REQ-031 SHALL cover: out_ready=0, all valid for 6 cycles -> 4 accepts (src 0..3), then child_ready=0, drop_cnt=2.
REQ-032 SHALL cover: FIFO full, out_ready=1 with child 1 valid -> push and pop same cycle, count stays 4, child_ready[1]=1.
REQ-033 SHALL cover: rst_n pulsed low mid-stream with 3 entries queued -> out_valid=0 immediately, count=0, next grant goes to child 0.
REQ-034 SHALL cover: drop_cnt preloaded near saturation via 65540 full-stall cycles -> drop_cnt=16'hFFFF held.

Source files
------------

// File: rtl/tree_pkg.sv
// Constants shared by the fan-in collector and its arbiter.
package tree_pkg;
  localparam int SRC_W     = 3;
  localparam int MAX_CHILD = 8;
endpackage

// File: rtl/tree_rr_arbiter.sv
// Round-robin arbiter: picks the first request at or after last_grant+1, wrapping at N.
module tree_rr_arbiter
  import tree_pkg::*;
#(
  parameter int N = 5
) (
  input  logic [N-1:0]     req_i,
  input  logic [SRC_W-1:0] last_grant_i,
  output logic [N-1:0]     grant_o,
  output logic [SRC_W-1:0] grant_idx_o
);

  int   idx;
  logic found;

  always_comb begin
    grant_o     = '0;
    grant_idx_o = '0;
    found       = 1'b0;
    idx         = 0;
    for (int off = 1; off <= N; off++) begin
      idx = (int'(last_grant_i) + off) % N;
      if (!found && req_i[idx]) begin
        found        = 1'b1;
        grant_o[idx] = 1'b1;
        grant_idx_o  = SRC_W'(idx);
      end
    end
  end

endmodule

// File: rtl/tree_fanin_collector.sv
// Merges NUM_CHILD valid/ready sources round-robin into a registered FIFO tagged with source index.
// Handshake: a beat moves on any port in a cycle where its valid and ready are both high; ready never waits on valid's history.
module tree_fanin_collector
  import tree_pkg::*;
#(
  parameter int NUM_CHILD = 5,
  parameter int DATA_W    = 8,
  parameter int DEPTH     = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_CHILD-1:0]        child_valid,
  input  logic [NUM_CHILD*DATA_W-1:0] child_data,
  output logic [NUM_CHILD-1:0]        child_ready,
  output logic                        out_valid,
  output logic [DATA_W-1:0]           out_data,
  output logic [SRC_W-1:0]            out_src,
  input  logic                        out_ready,
  output logic [15:0]                 drop_cnt
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int ENT_W = SRC_W + DATA_W;

  logic [NUM_CHILD-1:0] grant;
  logic [SRC_W-1:0]     grant_idx;
  logic [SRC_W-1:0]     last_grant_q, last_grant_d;
  logic [PTR_W-1:0]     wr_ptr_q, rd_ptr_q, rd_next;
  logic [CNT_W-1:0]     count_q, count_d, after_pop;
  logic [ENT_W-1:0]     mem_q [DEPTH];
  logic [ENT_W-1:0]     head_q, head_d, push_ent;
  logic [15:0]          drop_q, drop_d;
  logic                 full, pop, push, can_push;

  tree_rr_arbiter #(.N(NUM_CHILD)) u_arb (
    .req_i        (child_valid),
    .last_grant_i (last_grant_q),
    .grant_o      (grant),
    .grant_idx_o  (grant_idx)
  );

  // A pop in the same cycle frees a slot, so a full FIFO can still accept.
  assign full        = (count_q == CNT_W'(DEPTH));
  assign pop         = (count_q != '0) && out_ready;
  assign can_push    = !full || pop;
  assign child_ready = (rst_n && can_push) ? grant : '0;
  assign push        = |child_ready;
  assign push_ent    = {grant_idx, child_data[int'(grant_idx)*DATA_W +: DATA_W]};
  assign rd_next     = rd_ptr_q + PTR_W'(pop);
  assign after_pop   = count_q - CNT_W'(pop);

  always_comb begin
    count_d      = after_pop + CNT_W'(push);
    last_grant_d = push ? grant_idx : last_grant_q;
    head_d       = head_q;
    // Head register holds its last value once the FIFO drains.
    if (push && after_pop == '0) head_d = push_ent;
    else if (after_pop != '0)    head_d = mem_q[rd_next];
    drop_d = drop_q;
    if (|child_valid && !can_push && drop_q != 16'hFFFF) drop_d = drop_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      head_q       <= '0;
      drop_q       <= '0;
      last_grant_q <= SRC_W'(NUM_CHILD - 1);
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= push_ent;
        wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
      end
      rd_ptr_q     <= rd_next;
      count_q      <= count_d;
      head_q       <= head_d;
      drop_q       <= drop_d;
      last_grant_q <= last_grant_d;
    end
  end

  assign out_valid = (count_q != '0);
  assign out_src   = head_q[ENT_W-1 -: SRC_W];
  assign out_data  = head_q[DATA_W-1:0];
  assign drop_cnt  = drop_q;

endmodule

// File: tb/tb_tree_fanin_collector.sv
// Directed bench for tree_fanin_collector with a reference model and expected-output queue.
module tb_tree_fanin_collector;
  localparam int N = 5;
  localparam int W = 8;
  localparam int D = 4;

  logic           clk;
  logic           rst_n;
  logic [N-1:0]   child_valid;
  logic [N*W-1:0] child_data;
  logic [N-1:0]   child_ready;
  logic           out_valid;
  logic [W-1:0]   out_data;
  logic [2:0]     out_src;
  logic           out_ready;
  logic [15:0]    drop_cnt;

  int checks   = 0;
  int failures = 0;

  int m_last, m_cnt, m_drop;
  logic [10:0] exp_q[$];

  tree_fanin_collector #(.NUM_CHILD(N), .DATA_W(W), .DEPTH(D)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .child_valid (child_valid),
    .child_data  (child_data),
    .child_ready (child_ready),
    .out_valid   (out_valid),
    .out_data    (out_data),
    .out_src     (out_src),
    .out_ready   (out_ready),
    .drop_cnt    (drop_cnt)
  );

  // clock/reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_last = N - 1;
    m_cnt  = 0;
    m_drop = 0;
    exp_q.delete();
  endtask

  task automatic do_reset();
    rst_n       = 1'b0;
    child_valid = '0;
    child_data  = '0;
    out_ready   = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_drop_cnt", 32'(drop_cnt), 32'd0);
    rst_n = 1'b1;
  endtask

  // One clock: compare DUT against the model at the falling edge, then advance the model.
  task automatic tick(input bit chk);
    int win, idx;
    bit can_push, pop;
    logic [N-1:0] exp_rdy;
    @(negedge clk);
    win = -1;
    for (int off = 1; off <= N; off++) begin
      idx = (m_last + off) % N;
      if (win < 0 && child_valid[idx]) win = idx;
    end
    pop      = (m_cnt > 0) && out_ready;
    can_push = (m_cnt < D) || pop;
    exp_rdy  = '0;
    if (win >= 0 && can_push) exp_rdy[win] = 1'b1;
    if (chk) begin
      check("child_ready", 32'(child_ready), 32'(exp_rdy));
      check("out_valid", 32'(out_valid), 32'(m_cnt != 0));
      check("drop_cnt", 32'(drop_cnt), 32'(m_drop));
      if (m_cnt != 0) check("out_head", 32'({out_src, out_data}), 32'(exp_q[0]));
    end
    if (pop) begin
      void'(exp_q.pop_front());
      m_cnt--;
    end
    if (win >= 0 && can_push) begin
      exp_q.push_back({3'(win), child_data[win*W +: W]});
      m_cnt++;
      m_last = win;
    end
    if (|child_valid && !can_push && m_drop < 65535) m_drop++;
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int guard = 0;
    child_valid = '0;
    out_ready   = 1'b1;
    while (m_cnt > 0 && guard < 20) begin
      tick(1'b1);
      guard++;
    end
    check("drain_done", 32'(m_cnt), 32'd0);
  endtask

  initial begin
    do_reset();
    check("rst_ready", 32'(child_ready), 32'd0);

    // all children valid, output always ready: round-robin 0..4,0
    for (int i = 0; i < N; i++) child_data[i*W +: W] = 8'h10 + 8'(i);
    child_valid = '1;
    out_ready   = 1'b1;
    for (int j = 0; j < 6; j++) begin
      tick(1'b1);
      check("rr_src_seq", 32'(out_src), 32'(j % 5));
      check("rr_data_seq", 32'(out_data), 32'(8'h10 + 8'(j % 5)));
    end
    drain();

    // lone child 3
    child_data[3*W +: W] = 8'hA5;
    child_valid = 5'b01000;
    out_ready   = 1'b1;
    for (int j = 0; j < 4; j++) begin
      tick(1'b1);
      check("c3_data", 32'(out_data), 32'hA5);
      check("c3_src", 32'(out_src), 32'd3);
    end
    drain();

    // stalled output: fill then drop
    do_reset();
    for (int i = 0; i < N; i++) child_data[i*W +: W] = 8'h20 + 8'(i);
    child_valid = '1;
    out_ready   = 1'b0;
    for (int j = 0; j < 6; j++) tick(1'b1);
    check("full_ready", 32'(child_ready), 32'd0);
    check("full_drop", 32'(drop_cnt), 32'd2);

    // full with simultaneous pop: child 1 still accepted
    child_data[1*W +: W] = 8'h55;
    child_valid = 5'b00010;
    out_ready   = 1'b1;
    #1;
    check("pushpop_ready", 32'(child_ready), 32'b00010);
    tick(1'b1);
    out_ready   = 1'b0;
    child_valid = 5'b00001;
    #1;
    check("still_full", 32'(child_ready), 32'd0);
    check("still_valid", 32'(out_valid), 32'd1);
    drain();

    // reset mid-stream with 3 entries queued
    do_reset();
    child_data[2*W +: W] = 8'h3C;
    child_valid = 5'b00100;
    out_ready   = 1'b0;
    for (int j = 0; j < 3; j++) tick(1'b1);
    check("q3_valid", 32'(out_valid), 32'd1);
    child_valid = '1;
    #2 rst_n = 1'b0;
    #1;
    check("midrst_valid", 32'(out_valid), 32'd0);
    check("midrst_ready", 32'(child_ready), 32'd0);
    check("midrst_src", 32'(out_src), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
    for (int i = 0; i < N; i++) child_data[i*W +: W] = 8'h40 + 8'(i);
    out_ready = 1'b1;
    tick(1'b1);
    check("post_rst_src", 32'(out_src), 32'd0);
    check("post_rst_data", 32'(out_data), 32'h40);
    drain();

    // drop counter saturation
    do_reset();
    child_valid = '1;
    out_ready   = 1'b0;
    for (int j = 0; j < 4; j++) tick(1'b1);
    for (int j = 0; j < 65540; j++) tick(1'b0);
    check("drop_sat", 32'(drop_cnt), 32'hFFFF);
    for (int j = 0; j < 3; j++) tick(1'b1);
    check("drop_hold", 32'(drop_cnt), 32'hFFFF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
